// File: rtl/pipe_skid_chain_pkg.sv
// Shared definitions for elastic (valid/ready) pipeline blocks.
package pipe_skid_chain_pkg;

    // Occupancy of one skid stage; reused by other elastic blocks.
    typedef enum logic [1:0] {
        STAGE_EMPTY = 2'd0,
        STAGE_ONE   = 2'd1,
        STAGE_FULL  = 2'd2
    } stage_state_e;

    // Stage state follows from its valid bits; skid is only ever valid behind a valid main.
    function automatic stage_state_e stage_state(input logic main_vld, input logic skid_vld);
        if (skid_vld) begin
            return STAGE_FULL;
        end else if (main_vld) begin
            return STAGE_ONE;
        end else begin
            return STAGE_EMPTY;
        end
    endfunction

endpackage

// File: rtl/pipe_skid_chain_stage.sv
// One valid/ready skid stage: main + skid register, ready driven from flops only.
module skid_stage
    import pipe_skid_chain_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             main_vld_q, main_vld_d;
    logic             skid_vld_q, skid_vld_d;
    logic             in_xfer;
    logic             out_xfer;
    stage_state_e     state;

    assign in_ready  = ~skid_vld_q;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

    // Next-state for main/skid registers from the two port transfers.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;
        in_xfer    = in_valid & ~skid_vld_q;
        out_xfer   = main_vld_q & out_ready;
        state      = stage_state(main_vld_q, skid_vld_q);

        if (reset) begin
            main_d     = '0;
            skid_d     = '0;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (flush) begin
            // Data registers keep their contents; only occupancy is discarded.
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else begin
            case (state)
                STAGE_EMPTY: begin
                    if (in_xfer) begin
                        main_d     = in_data;
                        main_vld_d = 1'b1;
                    end
                end
                STAGE_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        skid_d     = in_data;
                        skid_vld_d = 1'b1;
                    end else if (!in_xfer && out_xfer) begin
                        main_vld_d = 1'b0;
                    end else if (in_xfer && out_xfer) begin
                        main_d = in_data;
                    end
                end
                STAGE_FULL: begin
                    if (out_xfer) begin
                        main_d     = skid_q;
                        skid_vld_d = 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Register update.
    always_ff @(posedge clk) begin
        main_q     <= main_d;
        skid_q     <= skid_d;
        main_vld_q <= main_vld_d;
        skid_vld_q <= skid_vld_d;
    end

endmodule

// File: rtl/pipe_skid_chain.sv
// Chain of DEPTH skid stages with synchronous flush and a registered occupancy count.
module pipe_skid_chain
    import pipe_skid_chain_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1,
    localparam int CW    = $clog2(2*DEPTH+1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
);

    logic [DEPTH:0]   vld;
    logic [DEPTH:0]   rdy;
    logic [WIDTH-1:0] dat [DEPTH+1];
    logic [CW-1:0]    count_q, count_d;

    assign vld[0]    = in_valid;
    assign dat[0]    = in_data;
    assign in_ready  = rdy[0];
    assign out_valid = vld[DEPTH];
    assign out_data  = dat[DEPTH];
    assign rdy[DEPTH] = out_ready;
    assign count     = count_q;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        skid_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .in_valid (vld[k]),
            .in_ready (rdy[k]),
            .in_data  (dat[k]),
            .out_valid(vld[k+1]),
            .out_ready(rdy[k+1]),
            .out_data (dat[k+1])
        );
    end

    // Occupancy tracks external transfers only; internal hand-offs do not change it.
    always_comb begin
        count_d = count_q;
        if (reset || flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(in_valid & rdy[0]) - CW'(vld[DEPTH] & out_ready);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

endmodule
